// File: rtl/spi_transaction_sequencer.sv
// SPI transaction sequencer: command FIFO -> timed start_comm pulses -> response FIFO.
// One transaction per queued byte, paced by an internal timer.
module spi_transaction_sequencer #(
  parameter int LENGTH_SEND     = 8,
  parameter int LENGTH_RECIEVED = 8,
  parameter int DEPTH           = 4,
  parameter int XFER_CYCLES     = 28,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [LENGTH_SEND-1:0]        cmd_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic [LENGTH_RECIEVED-1:0]    rsp_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [LENGTH_SEND-1:0]        data_send,
  output logic                          start_comm,
  input  logic [LENGTH_RECIEVED-1:0]    CIPO_register,
  output logic                          busy,
  output logic [$clog2(DEPTH):0]        cmd_level,
  output logic [$clog2(DEPTH):0]        rsp_level
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int MAXC = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, ARM, XFER, GAP} state_t;

  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic start_n;
  logic [LENGTH_SEND-1:0] data_n;

  logic [LENGTH_SEND-1:0] cmd_mem [DEPTH];
  logic [PW-1:0] cmd_wptr, cmd_rptr;
  logic cmd_push, cmd_pop;

  logic [LENGTH_RECIEVED-1:0] rsp_mem [DEPTH];
  logic [PW-1:0] rsp_wptr, rsp_rptr;
  logic rsp_push, rsp_pop;

  assign cmd_ready = (cmd_level != LW'(DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_valid = (rsp_level != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_mem[rsp_rptr];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= cmd_data;
    if (rsp_push) rsp_mem[rsp_wptr] <= CIPO_register;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_level <= '0;
      rsp_wptr  <= '0;
      rsp_rptr  <= '0;
      rsp_level <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
      if (cmd_pop)  cmd_rptr <= cmd_rptr + 1'b1;
      cmd_level <= cmd_level + LW'(cmd_push) - LW'(cmd_pop);
      if (rsp_push) rsp_wptr <= rsp_wptr + 1'b1;
      if (rsp_pop)  rsp_rptr <= rsp_rptr + 1'b1;
      rsp_level <= rsp_level + LW'(rsp_push) - LW'(rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      start_comm <= 1'b0;
      data_send  <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      start_comm <= start_n;
      data_send  <= data_n;
    end
  end

  // Space check uses registered rsp_level so the eventual capture always fits.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    start_n  = start_comm;
    data_n   = data_send;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && cmd_level != '0 && rsp_level != LW'(DEPTH)) begin
          cmd_pop = 1'b1;
          data_n  = cmd_mem[cmd_rptr];
          state_n = ARM;
        end
      end
      ARM: begin
        start_n = 1'b1;
        timer_n = '0;
        state_n = XFER;
      end
      XFER: begin
        if (timer == TW'(XFER_CYCLES - 1)) begin
          rsp_push = 1'b1;
          start_n  = 1'b0;
          timer_n  = '0;
          state_n  = GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Bench for spi_transaction_sequencer: directed scenarios with random bytes,
// checked against queue-based command/response model and pulse-timing rules.
module tb_spi_transaction_sequencer;

  localparam int XFER  = 28;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, enable, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic start_comm, busy;
  logic [7:0] cmd_data, rsp_data, data_send, CIPO_register;
  logic [2:0] cmd_level, rsp_level;

  int checks = 0;
  int failures = 0;
  int n_xfers = 0;

  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] force_q[$];

  spi_transaction_sequencer #(
    .LENGTH_SEND(8), .LENGTH_RECIEVED(8), .DEPTH(DEPTH),
    .XFER_CYCLES(XFER), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .data_send(data_send), .start_comm(start_comm),
    .CIPO_register(CIPO_register), .busy(busy),
    .cmd_level(cmd_level), .rsp_level(rsp_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Peripheral model and pulse-timing scoreboard, sampled mid-cycle.
  logic prev_start = 1'b0;
  logic [7:0] ds_prev = '0;
  logic [7:0] ds_rise = '0;
  int high_cnt = 0;
  int low_cnt = 100;

  always @(negedge clk) begin
    logic [7:0] v;
    if (rst) begin
      prev_start = 1'b0;
      high_cnt = 0;
      low_cnt = 100;
    end else begin
      if (start_comm && !prev_start) begin
        n_xfers++;
        chk("gap_low", low_cnt >= GAP + 2, 1);
        chk("xfer_has_cmd", exp_cmd_q.size() != 0, 1);
        if (exp_cmd_q.size() != 0) begin
          v = exp_cmd_q.pop_front();
          chk("ds_before_rise", ds_prev, v);
          chk("ds_at_rise", data_send, v);
        end
        ds_rise = data_send;
        v = (force_q.size() != 0) ? force_q.pop_front() : 8'($urandom);
        CIPO_register = v;
        exp_rsp_q.push_back(v);
        high_cnt = 1;
      end else if (start_comm) begin
        high_cnt++;
        chk("ds_stable", data_send, ds_rise);
      end else if (prev_start) begin
        chk("high_len", high_cnt, XFER);
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_rsp_q.size() != 0, 1);
        if (exp_rsp_q.size() != 0)
          chk("rsp_data", rsp_data, exp_rsp_q.pop_front());
      end
      prev_start = start_comm;
      ds_prev = data_send;
    end
  end

  task automatic push(input logic [7:0] b, input int bound, output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = b;
    for (int i = 0; i < bound; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        exp_cmd_q.push_back(b);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push_chk(input string tag, input logic [7:0] b);
    bit ok;
    push(b, 200, ok);
    chk(tag, ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!busy && cmd_level == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_rise(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (start_comm) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int n0;
    int lat;
    bit ok;
    rst = 1'b1;
    enable = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    CIPO_register = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start_comm, 0);
    chk("rst_data_send", data_send, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_level", cmd_level, 0);
    chk("rst_rsp_level", rsp_level, 0);
    rst = 1'b0;

    // Single transaction with fixed bytes
    enable = 1'b1;
    rsp_ready = 1'b1;
    force_q.push_back(8'h3C);
    push_chk("t1_accept", 8'hA5);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("t1_latency", lat, 30);
    chk("t1_rsp", rsp_data, 8'h3C);
    wait_idle("t1_idle");

    // Back-to-back
    n0 = n_xfers;
    push_chk("t2_push1", 8'h01);
    push_chk("t2_push2", 8'h02);
    push_chk("t2_push3", 8'h03);
    wait_idle("t2_idle");
    chk("t2_xfers", n_xfers - n0, 3);

    // Response FIFO full stall
    rsp_ready = 1'b0;
    n0 = n_xfers;
    for (int i = 0; i < 6; i++) push_chk("t3_push", 8'($urandom));
    repeat (200) @(posedge clk);
    #1;
    chk("t3_xfers", n_xfers - n0, 4);
    chk("t3_busy", busy, 0);
    chk("t3_cmd_level", cmd_level, 2);
    chk("t3_rsp_level", rsp_level, 4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t3_busy_pop_cycle", busy, 0);
    @(posedge clk); #1;
    chk("t3_busy_after", busy, 1);
    chk("t3_cmd_level_after", cmd_level, 1);
    repeat (60) @(posedge clk);
    #1;
    chk("t3_xfers_one_more", n_xfers - n0, 5);
    chk("t3_busy_stall2", busy, 0);
    chk("t3_rsp_level2", rsp_level, 4);
    rsp_ready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_xfers_total", n_xfers - n0, 6);

    // Command FIFO full with enable low
    enable = 1'b0;
    n0 = n_xfers;
    for (int i = 0; i < 4; i++) push_chk("t4_push", 8'($urandom));
    chk("t4_cmd_ready", cmd_ready, 0);
    chk("t4_cmd_level", cmd_level, 4);
    push(8'($urandom), 5, ok);
    chk("t4_fifth_rejected", ok, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_no_xfer", n_xfers - n0, 0);
    chk("t4_start_low", start_comm, 0);
    enable = 1'b1;
    wait_idle("t4_idle");
    chk("t4_xfers", n_xfers - n0, 4);

    // Reset mid-transfer
    n0 = n_xfers;
    push_chk("t5_push", 8'($urandom));
    wait_rise("t5_rise");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_start", start_comm, 0);
    chk("t5_cmd_level", cmd_level, 0);
    chk("t5_rsp_level", rsp_level, 0);
    chk("t5_busy", busy, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_xfers", n_xfers - n0, 1);

    // enable dropped mid-transfer
    n0 = n_xfers;
    for (int i = 0; i < 3; i++) push_chk("t6_push", 8'($urandom));
    wait_rise("t6_rise");
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_xfers", n_xfers - n0, 1);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_level", cmd_level, 2);
    chk("t6_rsp_drained", exp_rsp_q.size(), 0);
    chk("t6_start", start_comm, 0);
    enable = 1'b1;
    wait_idle("t6_idle");
    chk("t6_xfers_total", n_xfers - n0, 3);

    chk("end_cmd_q", exp_cmd_q.size(), 0);
    chk("end_rsp_q", exp_rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
